// File: rtl/mem_responder.sv
// mem_responder: handshake data-memory target with fixed response latency and a
// free-running registered instruction-fetch read port on the same word array.
// Optional feature macro: MEM_RANGE_CHECK_EN (flags out-of-range addresses with
// resp_err, suppresses such writes and returns zero data for them).
module mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // With a one-cycle latency the response is due right after acceptance.
    localparam state_t     ACCEPT_STATE = (LATENCY == 1) ? RESP : WAIT;
    localparam logic [3:0] CNT_INIT     = 4'(LATENCY - 1);

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          no_data_reg;
    logic [31:0]   rd_reg;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] req_idx;
    logic [AW-1:0] instr_idx;
    logic          req_oor;
    logic          instr_oor;
    logic          accept;

    assign req_idx   = req_addr[AW-1:0];
    assign instr_idx = instr_addr[AW-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign req_oor   = |req_addr[31:AW];
    assign instr_oor = |instr_addr[31:AW];
`else
    // Addresses wrap modulo DEPTH; the upper bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW], instr_addr[31:AW]};
    assign req_oor   = 1'b0;
    assign instr_oor = 1'b0;
`endif

    // Ready is withheld while reset is asserted so nothing commits during reset.
    assign req_ready  = rst_n && (state_reg == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    // Writes and out-of-range reads return zero; data is only exposed in RESP.
    assign resp_rdata = (resp_valid && !no_data_reg) ? rd_reg : 32'd0;

    // Data port: write commits and read data is captured at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (req_we && !req_oor) begin
                mem[req_idx] <= req_wdata;
            end
            rd_reg <= mem[req_idx];
        end
    end

    // Instruction port: registered read every edge, old data on a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_data <= 32'd0;
        end else if (instr_oor) begin
            instr_data <= 32'd0;
        end else begin
            instr_data <= mem[instr_idx];
        end
    end

    // Control state: FSM state, latency counter and per-transaction attributes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            no_data_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                no_data_reg <= req_we || req_oor;
            end
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    logic err_reg;

    // Range error travels with the transaction and is shown with the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= req_oor;
        end
    end

    assign resp_err = resp_valid && err_reg;
`else
    assign resp_err = 1'b0;
`endif

    // Next-state logic: IDLE -> WAIT (count down) -> RESP (hold until taken) -> IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ACCEPT_STATE;
                    cnt_next   = CNT_INIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized transactions checked every cycle against a
// transaction-level model (memory array + age of the outstanding request),
// plus directed scenarios with literal expectations.
module tb_mem_responder;

    localparam int DEPTH   = 16;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event time=%0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    bit          m_started = 0;
    bit          m_pend    = 0;
    int          m_age     = 0;   // edges since acceptance
    logic [31:0] m_data    = 0;
    bit          m_dknown  = 1;
    bit          m_err     = 0;
    logic [31:0] e_instr   = 0;
    bit          e_iknown  = 1;

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return a >= 32'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl_known[i] = 0;
        forever begin
            int  ii;
            int  ri;
            bit  roor;
            @(posedge clk);
            m_started = 1;
            if (!rst_n) begin
                m_pend   = 0;
                m_age    = 0;
                e_instr  = 0;
                e_iknown = 1;
            end else begin
                ii = int'(instr_addr % 32'(DEPTH));
                if (out_of_range(instr_addr)) begin
                    e_instr  = 0;
                    e_iknown = 1;
                end else begin
                    e_instr  = mdl_mem[ii];
                    e_iknown = mdl_known[ii];
                end
                if (m_pend) begin
                    if (m_age >= LATENCY && resp_ready) m_pend = 0;
                    else if (m_age < 1000) m_age++;
                end else if (req_valid) begin
                    ri       = int'(req_addr % 32'(DEPTH));
                    roor     = out_of_range(req_addr);
                    m_pend   = 1;
                    m_age    = 1;
                    m_err    = roor;
                    m_dknown = 1;
                    if (req_we || roor) m_data = 0;
                    else begin
                        m_data   = mdl_mem[ri];
                        m_dknown = mdl_known[ri];
                    end
                    if (req_we && !roor) begin
                        mdl_mem[ri]   = req_wdata;
                        mdl_known[ri] = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            bit ev;
            @(negedge clk);
            #1;
            if (m_started) begin
                ev = m_pend && (m_age >= LATENCY);
                cmp("req_ready", 32'(req_ready), 32'(rst_n && !m_pend));
                cmp("resp_valid", 32'(resp_valid), 32'(ev));
                cmp("busy", 32'(busy), 32'(m_pend));
                cmp("resp_err", 32'(resp_err), 32'(ev && m_err));
                if (!ev) cmp("resp_rdata_idle", resp_rdata, 32'd0);
                else if (m_dknown) cmp("resp_rdata", resp_rdata, m_data);
                if (e_iknown) cmp("instr_data", instr_data, e_instr);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit          instr_hold = 1;
    logic [31:0] cap1, cap2;

    initial begin
        forever begin
            @(negedge clk);
            if (!instr_hold) instr_addr = $urandom_range(0, 2 * DEPTH - 1);
        end
    end

    task automatic randomize_noise();
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom_range(0, 2 * DEPTH - 1);
        req_wdata = $urandom;
    endtask

    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input bit noise,
                          output logic [31:0] rdata, output bit err, output int lat);
        int guard;
        rdata = 32'hDEAD_BEEF;
        err   = 1'b0;
        lat   = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        #1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!req_ready) begin
            timeout_fail("req_accept");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        if (noise) randomize_noise();
        else req_valid = 1'b0;
        lat  = 1;
        cap1 = instr_data;
        while (!resp_valid && lat < 40) begin
            resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            lat++;
            if (lat == 2) cap2 = instr_data;
            if (noise) randomize_noise();
        end
        if (!resp_valid) begin
            timeout_fail("resp_valid_wait");
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            return;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            @(negedge clk);
            #1;
            if (noise) randomize_noise();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        $display("TXN we=%0d addr=%0d wdata=%h rdata=%h err=%0d lat=%0d hold=%0d",
                 we, addr, wdata, rdata, err, lat, hold);
    endtask

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lt;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        instr_addr = 32'd0;

        // Reset: two edges with rst_n low.
        @(negedge clk);
        #1;
        cmp("rst_req_ready", 32'(req_ready), 32'd0);
        cmp("rst_resp_valid", 32'(resp_valid), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_resp_rdata", resp_rdata, 32'd0);
        cmp("rst_instr_data", instr_data, 32'd0);
        @(negedge clk);
        #1;
        cmp("rst_req_ready2", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        cmp("post_rst_req_ready", 32'(req_ready), 32'd1);
        cmp("post_rst_instr_data", instr_data, 32'd0);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i), $urandom, 0, 1'b0, rd, er, lt);

        // Write then read address 3.
        do_txn(1'b1, 32'd3, 32'h0000_000A, 0, 1'b0, rd, er, lt);
        cmp("wr_resp_rdata_zero", rd, 32'd0);
        do_txn(1'b0, 32'd3, 32'd0, 0, 1'b0, rd, er, lt);
        cmp("rd3_data", rd, 32'h0000_000A);
        cmp("rd3_latency", 32'(lt), 32'd2);

        // Backpressure for 5 cycles with ignored request noise.
        do_txn(1'b0, 32'd3, 32'd0, 5, 1'b1, rd, er, lt);
        cmp("bp_data", rd, 32'h0000_000A);
        cmp("bp_idle_busy", 32'(busy), 32'd0);
        cmp("bp_idle_ready", 32'(req_ready), 32'd1);

        // Instruction-port collision on address 7.
        @(negedge clk);
        instr_hold = 1;
        instr_addr = 32'd7;
        do_txn(1'b1, 32'd7, 32'h0000_0055, 0, 1'b0, rd, er, lt);
        do_txn(1'b1, 32'd7, 32'h0000_1234, 0, 1'b0, rd, er, lt);
        cmp("instr_old_at_write", cap1, 32'h0000_0055);
        cmp("instr_new_next", cap2, 32'h0000_1234);
        instr_hold = 0;

        // Wrap / range check.
        do_txn(1'b1, 32'd1, 32'h0000_0077, 0, 1'b0, rd, er, lt);
        do_txn(1'b1, 32'(DEPTH + 1), 32'h0000_0005, 0, 1'b0, rd, er, lt);
`ifdef MEM_RANGE_CHECK_EN
        cmp("oor_err", 32'(er), 32'd1);
        do_txn(1'b0, 32'd1, 32'd0, 0, 1'b0, rd, er, lt);
        cmp("oor_rd1_unchanged", rd, 32'h0000_0077);
`else
        cmp("wrap_err", 32'(er), 32'd0);
        do_txn(1'b0, 32'd1, 32'd0, 0, 1'b0, rd, er, lt);
        cmp("wrap_rd1", rd, 32'h0000_0005);
`endif

        // Reset during WAIT after an accepted write of 0xF to address 2.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd2;
        req_wdata = 32'h0000_000F;
        #1;
        cmp("midwait_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        cmp("midwait_valid0", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            cmp("midwait_valid_rst", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        do_txn(1'b0, 32'd2, 32'd0, 0, 1'b0, rd, er, lt);
        cmp("midwait_rd2", rd, 32'h0000_000F);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom_range(0, 2 * DEPTH - 1), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, er, lt);
        end

        repeat (3) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
